// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch adjust front end.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_MINL = 3'd1,
        SEL_MINR = 3'd2,
        SEL_SECL = 3'd3,
        SEL_SECR = 3'd4
    } digit_sel_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEL_ML = 3'd1,
        ST_SEL_MR = 3'd2,
        ST_SEL_SL = 3'd3,
        ST_SEL_SR = 3'd4
    } adj_state_t;

    localparam logic [3:0] LIMIT_MIN_L = 4'd9;
    localparam logic [3:0] LIMIT_MIN_R = 4'd9;
    localparam logic [3:0] LIMIT_SEC_L = 4'd5;
    localparam logic [3:0] LIMIT_SEC_R = 4'd9;

    // Highest legal value of the digit being edited in a given state.
    function automatic logic [3:0] digit_limit(input adj_state_t s);
        case (s)
            ST_SEL_ML: digit_limit = LIMIT_MIN_L;
            ST_SEL_MR: digit_limit = LIMIT_MIN_R;
            ST_SEL_SL: digit_limit = LIMIT_SEC_L;
            default:   digit_limit = LIMIT_SEC_R;
        endcase
    endfunction

    // Digit-select cycle ML -> MR -> SL -> SR -> ML.
    function automatic adj_state_t next_digit(input adj_state_t s);
        case (s)
            ST_SEL_ML: next_digit = ST_SEL_MR;
            ST_SEL_MR: next_digit = ST_SEL_SL;
            ST_SEL_SL: next_digit = ST_SEL_SR;
            default:   next_digit = ST_SEL_ML;
        endcase
    endfunction

    // Encoding of adj_sel for each state; SEL_NONE when idle.
    function automatic digit_sel_t sel_of(input adj_state_t s);
        case (s)
            ST_SEL_ML: sel_of = SEL_MINL;
            ST_SEL_MR: sel_of = SEL_MINR;
            ST_SEL_SL: sel_of = SEL_SECL;
            ST_SEL_SR: sel_of = SEL_SECR;
            default:   sel_of = SEL_NONE;
        endcase
    endfunction

    // Wrap-limited increment; out-of-range values also fold back to 0.
    function automatic logic [3:0] wrap_inc(input logic [3:0] v, input logic [3:0] lim);
        wrap_inc = (v >= lim) ? 4'd0 : v + 4'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, DEB_COUNT-sample level filter, rising-edge pulse.
// Latency: 2 clk sync plus DEB_COUNT sample_en ticks; rise is a registered 1-clk pulse.
// Backpressure: none; the filter only advances on sample_en.
module btn_debounce #(
    parameter int unsigned DEB_COUNT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_en,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int unsigned CW = $clog2(DEB_COUNT + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b00;
        else        sync <= {sync[0], btn};
    end

    // Accept a new level only after DEB_COUNT consecutive differing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (sample_en) begin
                if (sync[1] == level) begin
                    cnt <= '0;
                end else if (cnt == CW'(DEB_COUNT - 1)) begin
                    level <= sync[1];
                    rise  <= sync[1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/adjust_ctrl.sv
// Stopwatch adjust front end: debounced buttons drive a digit-select FSM emitting adj/adj_sel/adj_val/adj_we.
// Latency: write strobe and new adj_val appear 1 clk after a debounced inc pulse.
// Backpressure: none; the counter must accept every adj_we. Optional ADJ_AUTOREPEAT_EN adds held-inc repeats.
module adjust_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEB_COUNT   = 4,
    parameter int unsigned BLINK_DIV   = 250,
    parameter int unsigned REPEAT_HOLD = 500,
    parameter int unsigned REPEAT_RATE = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_en,
    input  logic       adj_sw,
    input  logic       btn_sel,
    input  logic       btn_inc,
    input  logic [3:0] cur_min_l,
    input  logic [3:0] cur_min_r,
    input  logic [3:0] cur_sec_l,
    input  logic [3:0] cur_sec_r,
    output logic       adj,
    output logic [2:0] adj_sel,
    output logic [3:0] adj_val,
    output logic       adj_we,
    output logic       blink
);

    localparam int unsigned BW = $clog2(BLINK_DIV + 1);

    adj_state_t    state;
    adj_state_t    nxt_digit;
    logic [3:0]    load_val;
    logic [BW-1:0] blink_cnt;
    logic          sel_lvl, sel_pulse;
    logic          inc_lvl, inc_pulse;
    logic          inc_evt;

    btn_debounce #(.DEB_COUNT(DEB_COUNT)) u_deb_sel (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .btn(btn_sel),
        .level(sel_lvl), .rise(sel_pulse)
    );

    btn_debounce #(.DEB_COUNT(DEB_COUNT)) u_deb_inc (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .btn(btn_inc),
        .level(inc_lvl), .rise(inc_pulse)
    );

`ifdef ADJ_AUTOREPEAT_EN
    logic [15:0] rep_cnt;
    logic        rep_pulse;
    logic        unused_lvl;

    assign unused_lvl = sel_lvl;

    // Count sample ticks while inc is held; first repeat at REPEAT_HOLD, then every REPEAT_RATE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt   <= '0;
            rep_pulse <= 1'b0;
        end else begin
            rep_pulse <= 1'b0;
            if (!inc_lvl || !adj) begin
                rep_cnt <= '0;
            end else if (sample_en) begin
                if (rep_cnt == 16'(REPEAT_HOLD - 1)) begin
                    rep_pulse <= 1'b1;
                    rep_cnt   <= 16'(REPEAT_HOLD - REPEAT_RATE);
                end else begin
                    rep_cnt <= rep_cnt + 16'd1;
                end
            end
        end
    end

    assign inc_evt = inc_pulse | rep_pulse;
`else
    logic unused_cfg;

    assign unused_cfg = ^{sel_lvl, inc_lvl, REPEAT_HOLD[0], REPEAT_RATE[0]};
    assign inc_evt    = inc_pulse;
`endif

    assign nxt_digit = (state == ST_IDLE) ? ST_SEL_ML : next_digit(state);

    // Current counter value of the digit about to be selected.
    always_comb begin
        load_val = cur_min_l;
        case (nxt_digit)
            ST_SEL_MR: load_val = cur_min_r;
            ST_SEL_SL: load_val = cur_sec_l;
            ST_SEL_SR: load_val = cur_sec_r;
            default:   load_val = cur_min_l;
        endcase
    end

    // Digit-select FSM with registered outputs; adj_sw low overrides everything, inc beats sel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            adj       <= 1'b0;
            adj_sel   <= SEL_NONE;
            adj_val   <= 4'd0;
            adj_we    <= 1'b0;
            blink     <= 1'b0;
            blink_cnt <= '0;
        end else begin
            adj_we <= 1'b0;
            if (!adj_sw) begin
                state     <= ST_IDLE;
                adj       <= 1'b0;
                adj_sel   <= SEL_NONE;
                adj_val   <= 4'd0;
                blink     <= 1'b0;
                blink_cnt <= '0;
            end else if (state == ST_IDLE || (sel_pulse && !inc_evt)) begin
                state     <= nxt_digit;
                adj       <= 1'b1;
                adj_sel   <= sel_of(nxt_digit);
                adj_val   <= load_val;
                blink     <= 1'b1;
                blink_cnt <= '0;
            end else if (inc_evt) begin
                adj_val   <= wrap_inc(adj_val, digit_limit(state));
                adj_we    <= 1'b1;
                blink     <= 1'b1;
                blink_cnt <= '0;
            end else if (sample_en) begin
                if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                    blink     <= ~blink;
                    blink_cnt <= '0;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_adjust_ctrl.sv
// Self-checking bench for adjust_ctrl: directed scenarios plus random button sequences against a digit-level model.
// Latency: checks taken on the falling clock edge after each debounced action settles.
// Backpressure: n/a. Define ADJ_AUTOREPEAT_EN to also exercise held-inc auto-repeat.
module tb_adjust_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_en = 1'b0;
    logic       adj_sw = 1'b0;
    logic       btn_sel = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] cur_min_l = 4'd0;
    logic [3:0] cur_min_r = 4'd0;
    logic [3:0] cur_sec_l = 4'd0;
    logic [3:0] cur_sec_r = 4'd0;
    logic       adj;
    logic [2:0] adj_sel;
    logic [3:0] adj_val;
    logic       adj_we;
    logic       blink;

    adjust_ctrl dut (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .adj_sw(adj_sw),
        .btn_sel(btn_sel), .btn_inc(btn_inc),
        .cur_min_l(cur_min_l), .cur_min_r(cur_min_r), .cur_sec_l(cur_sec_l), .cur_sec_r(cur_sec_r),
        .adj(adj), .adj_sel(adj_sel), .adj_val(adj_val), .adj_we(adj_we), .blink(blink)
    );

    always #5 clk = ~clk;

    // sample_en: one clk high every four clks
    always begin
        repeat (3) @(posedge clk);
        #1 sample_en = 1'b1;
        @(posedge clk);
        #1 sample_en = 1'b0;
    end

    int checks = 0;
    int failures = 0;
    int we_idle = 0;
    logic [6:0] wq[$];      // observed writes {adj_sel, adj_val}
    logic [6:0] exp_q[$];   // expected writes from the model

    // model state: digit index 0 (not adjusting) .. 4, working value
    int md = 0;
    int mv = 0;
    int lim[5] = '{0, 9, 9, 5, 9};

    // record every write the DUT emits
    always @(negedge clk) begin
        if (rst_n && adj_we) begin
            wq.push_back({adj_sel, adj_val});
            if (!adj) we_idle++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(negedge clk);
            if (sample_en) k++;
        end
    endtask

    function automatic int cur_of(input int d);
        case (d)
            1: return int'(cur_min_l);
            2: return int'(cur_min_r);
            3: return int'(cur_sec_l);
            default: return int'(cur_sec_r);
        endcase
    endfunction

    function automatic void m_sel();
        if (md != 0) begin
            md = (md == 4) ? 1 : md + 1;
            mv = cur_of(md);
        end
    endfunction

    function automatic void m_inc();
        logic [2:0] s;
        logic [3:0] v;
        if (md != 0) begin
            mv = (mv >= lim[md]) ? 0 : mv + 1;
            s = 3'(md);
            v = 4'(mv);
            exp_q.push_back({s, v});
        end
    endfunction

    task automatic set_sw(input logic v);
        @(negedge clk);
        adj_sw = v;
        wait_ticks(2);
        if (v && md == 0) begin
            md = 1;
            mv = cur_of(1);
        end else if (!v) begin
            md = 0;
            mv = 0;
        end
    endtask

    // which: 0 = sel, 1 = inc, 2 = both together
    task automatic press(input int which, input int hold);
        @(negedge clk);
        if (which != 1) btn_sel = 1'b1;
        if (which != 0) btn_inc = 1'b1;
        wait_ticks(hold);
        btn_sel = 1'b0;
        btn_inc = 1'b0;
        wait_ticks(8);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_adj"}, 32'(adj), 32'(md != 0));
        chk({tag, "_sel"}, 32'(adj_sel), 32'(md));
        chk({tag, "_val"}, 32'(adj_val), 32'(mv));
        chk({tag, "_nwr"}, 32'(wq.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wq.size(); i++)
            chk({tag, "_wr"}, 32'(wq[i]), 32'(exp_q[i]));
        wq.delete();
        exp_q.delete();
    endtask

    task automatic rand_cur();
        cur_min_l = 4'($urandom_range(0, 15));
        cur_min_r = 4'($urandom_range(0, 15));
        cur_sec_l = 4'($urandom_range(0, 15));
        cur_sec_r = 4'($urandom_range(0, 15));
    endtask

    initial begin
        // power-on reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("por_outs", 32'({adj, adj_sel, adj_val, adj_we, blink}), 32'd0);
        rst_n = 1'b1;
        wait_ticks(4);
        chk("idle_outs", 32'({adj, adj_sel, adj_val, adj_we, blink}), 32'd0);

        // bouncy inc press on min_l
        cur_min_l = 4'($urandom_range(0, 8));
        set_sw(1'b1);
        check_model("enter");
        chk("enter_blink", 32'(blink), 32'd1);
        @(negedge clk);
        btn_inc = 1'b1;
        wait_ticks(1);
        btn_inc = 1'b0;
        wait_ticks(1);
        btn_inc = 1'b1;
        wait_ticks(8);
        btn_inc = 1'b0;
        wait_ticks(8);
        m_inc();
        check_model("bounce");

        // sec_l wraps at 5
        cur_sec_l = 4'd4;
        press(0, 8); m_sel(); check_model("wrap_sel1");
        press(0, 8); m_sel(); check_model("wrap_sel2");
        press(1, 8); m_inc(); check_model("wrap_inc1");
        press(1, 8); m_inc(); check_model("wrap_inc2");

        // reset mid-adjust with adj_val=3 in SEL_SL
        set_sw(1'b0);
        cur_sec_l = 4'd3;
        set_sw(1'b1);
        press(0, 8); m_sel();
        press(0, 8); m_sel();
        check_model("pre_rst");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_outs", 32'({adj, adj_sel, adj_val, adj_we, blink}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        md = 1;
        mv = cur_of(1);
        wait_ticks(4);
        check_model("post_rst");

        // select wraps through all digits with fresh counter values
        for (int i = 0; i < 5; i++) begin
            rand_cur();
            press(0, 8);
            m_sel();
            check_model("selwrap");
        end

        // sel and inc together in SEL_MR with min_r=9
        set_sw(1'b0);
        set_sw(1'b1);
        cur_min_r = 4'd9;
        press(0, 8); m_sel(); check_model("coll_sel");
        press(2, 8); m_inc(); check_model("coll_both");
        set_sw(1'b0);
        chk("exit_outs", 32'({adj, adj_sel, blink}), 32'd0);

        // blink toggles after the blink period and restarts on a write
        set_sw(1'b1);
        wait_ticks(260);
        chk("blink_toggle", 32'(blink), 32'd0);
        press(1, 8); m_inc();
        check_model("blink_wr");
        chk("blink_restart", 32'(blink), 32'd1);

        // random button sequences
        for (int i = 0; i < 24; i++) begin
            int op;
            rand_cur();
            op = $urandom_range(0, 5);
            if (op <= 2) begin
                press(1, 8); m_inc();
            end else if (op <= 4) begin
                press(0, 8); m_sel();
            end else begin
                set_sw(!adj_sw);
            end
            check_model("rand");
        end

`ifdef ADJ_AUTOREPEAT_EN
        // held inc on sec_r from 0: press write plus three repeats
        set_sw(1'b0);
        set_sw(1'b1);
        cur_sec_r = 4'd0;
        press(0, 8); m_sel();
        press(0, 8); m_sel();
        press(0, 8); m_sel();
        check_model("rep_pre");
        press(1, 780);
        m_inc(); m_inc(); m_inc(); m_inc();
        check_model("rep_hold");
`endif

        chk("we_in_idle", 32'(we_idle), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
